// File: rtl/deinterleaver_if.sv
// Serial coded-bit stream into the deinterleaver and the reordered stream out of it.
// The master side drives the received bits; the slave side is the deinterleaver.
interface deinterleaver_if;
  logic in_dat;
  logic in_vld;
  logic flush;
  logic out_dat;
  logic out_vld;
  logic out_start;

  modport master (
    output in_dat, in_vld, flush,
    input  out_dat, out_vld, out_start
  );

  modport slave (
    input  in_dat, in_vld, flush,
    output out_dat, out_vld, out_start
  );
endinterface

// File: rtl/deinterleaver.sv
// 802.11a receive deinterleaver (s=1): ping-pong banks, one fills while the other drains.
// The first output bit is registered one edge after the last input bit of a symbol.
module deinterleaver #(
  parameter int N_CBPS = 48
) (
  input logic           clk,
  input logic           rst,
  deinterleaver_if.slave bus
);
  localparam int N_ROWS = N_CBPS / 16;
  localparam int AW     = $clog2(N_CBPS);

  typedef enum logic {IDLE, DRAIN} state_t;

  logic [N_CBPS-1:0] bank0_q, bank0_d;
  logic [N_CBPS-1:0] bank1_q, bank1_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [6:0]        w_cnt_q, w_cnt_d;
  logic [6:0]        r_cnt_q, r_cnt_d;
  state_t            state_q, state_d;
  logic              out_dat_q, out_dat_d;
  logic              out_vld_q, out_vld_d;
  logic              out_start_q, out_start_d;

  logic              handoff;
  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     col;
  logic [AW-1:0]     row;
  logic [AW-1:0]     rd_addr;
  logic              rd_bit;

  assign w_idx = w_cnt_q[AW-1:0];

  // Write side: flush beats a valid bit on the same edge.
  always_comb begin
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    w_cnt_d = w_cnt_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    handoff = 1'b0;
    if (bus.flush) begin
      w_cnt_d = '0;
    end else if (bus.in_vld) begin
      if (wbank_q) bank1_d[w_idx] = bus.in_dat;
      else         bank0_d[w_idx] = bus.in_dat;
      if (w_cnt_q == 7'(N_CBPS - 1)) begin
        w_cnt_d = '0;
        wbank_d = ~wbank_q;
        rbank_d = wbank_q;
        handoff = 1'b1;
      end else begin
        w_cnt_d = w_cnt_q + 7'd1;
      end
    end
  end

  // Read address ROWS*(k mod 16) + floor(k/16), built from shifts only.
  assign col = AW'(r_cnt_q[3:0]);
  assign row = AW'(r_cnt_q[6:4]);
  if (N_ROWS == 6) begin : g_rows6
    assign rd_addr = (col << 2) + (col << 1) + row;
  end else begin : g_rows3
    assign rd_addr = (col << 1) + col + row;
  end
  assign rd_bit = rbank_q ? bank1_q[rd_addr] : bank0_q[rd_addr];

  always_comb begin
    state_d = state_q;
    r_cnt_d = r_cnt_q;
    case (state_q)
      IDLE: ;
      DRAIN: begin
        if (r_cnt_q == 7'(N_CBPS - 1)) state_d = IDLE;
        else                           r_cnt_d = r_cnt_q + 7'd1;
      end
      default: state_d = IDLE;
    endcase
    // A hand-off on the final drain edge chains straight into the next symbol.
    if (handoff) begin
      state_d = DRAIN;
      r_cnt_d = '0;
    end
  end

  always_comb begin
    out_dat_d   = out_dat_q;
    out_vld_d   = 1'b0;
    out_start_d = 1'b0;
    if (state_q == DRAIN) begin
      out_dat_d   = rd_bit;
      out_vld_d   = 1'b1;
      out_start_d = (r_cnt_q == 7'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0_q     <= '0;
      bank1_q     <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      w_cnt_q     <= '0;
      r_cnt_q     <= '0;
      state_q     <= IDLE;
      out_dat_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_start_q <= 1'b0;
    end else begin
      bank0_q     <= bank0_d;
      bank1_q     <= bank1_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      w_cnt_q     <= w_cnt_d;
      r_cnt_q     <= r_cnt_d;
      state_q     <= state_d;
      out_dat_q   <= out_dat_d;
      out_vld_q   <= out_vld_d;
      out_start_q <= out_start_d;
    end
  end

  assign bus.out_dat   = out_dat_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.out_start = out_start_q;
endmodule

// File: tb/tb_deinterleaver.sv
// Drives a 48-bit and a 96-bit deinterleaver with random symbols and checks every output
// cycle against a reference that scatters each received bit to its original position.
module tb_deinterleaver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deinterleaver_if bus48 ();
  deinterleaver_if bus96 ();

  deinterleaver #(.N_CBPS(48)) u_dut48 (.clk(clk), .rst(rst), .bus(bus48.slave));
  deinterleaver #(.N_CBPS(96)) u_dut96 (.clk(clk), .rst(rst), .bus(bus96.slave));

  localparam int MAXC = 8192;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  bit cap_en  = 1'b0;

  bit exp_vld [2][MAXC];
  bit exp_bit [2][MAXC];
  bit exp_st  [2][MAXC];
  bit rx_buf  [2][96];
  int rx_n    [2];
  bit cap     [2][1024];
  int cap_n   [2];
  int st_n    [2];

  bit orig [480];
  bit tx   [480];

  int   m_n, m_rows, m_k;
  logic m_v, m_f, m_b;
  logic mo_v, mo_d, mo_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: received bit i of a symbol belongs at coded position 16*(i mod ROWS) + i/ROWS,
  // and position k is emitted k+1 edges after the edge that completes the symbol.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      m_n    = (d == 0) ? 48 : 96;
      m_rows = m_n / 16;
      m_v    = (d == 0) ? bus48.in_vld : bus96.in_vld;
      m_f    = (d == 0) ? bus48.flush  : bus96.flush;
      m_b    = (d == 0) ? bus48.in_dat : bus96.in_dat;
      if (rst || m_f) begin
        rx_n[d] = 0;
      end else if (m_v) begin
        rx_buf[d][rx_n[d]] = m_b;
        rx_n[d]++;
        if (rx_n[d] == m_n) begin
          for (int i = 0; i < m_n; i++) begin
            m_k = 16 * (i % m_rows) + i / m_rows;
            if (cyc + 1 + m_k < MAXC) begin
              exp_vld[d][cyc+1+m_k] = 1'b1;
              exp_bit[d][cyc+1+m_k] = rx_buf[d][i];
              exp_st[d][cyc+1+m_k]  = (m_k == 0);
            end
          end
          rx_n[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && cyc < MAXC) begin
      for (int d = 0; d < 2; d++) begin
        mo_v = (d == 0) ? bus48.out_vld   : bus96.out_vld;
        mo_d = (d == 0) ? bus48.out_dat   : bus96.out_dat;
        mo_s = (d == 0) ? bus48.out_start : bus96.out_start;
        check($sformatf("out_vld[%0d]@%0d", d, cyc), mo_v, exp_vld[d][cyc]);
        if (exp_vld[d][cyc]) begin
          check($sformatf("out_dat[%0d]@%0d", d, cyc), mo_d, exp_bit[d][cyc]);
          check($sformatf("out_start[%0d]@%0d", d, cyc), mo_s, exp_st[d][cyc]);
        end
        if (cap_en && mo_v) begin
          if (cap_n[d] < 1024) cap[d][cap_n[d]] = mo_d;
          cap_n[d]++;
          if (mo_s) st_n[d]++;
        end
      end
    end
  end

  task automatic drv(input int d, input logic b, input logic v, input logic f);
    bus48.in_dat = (d == 0) ? b : 1'b0;
    bus48.in_vld = (d == 0) && v;
    bus48.flush  = (d == 0) && f;
    bus96.in_dat = (d == 1) ? b : 1'b0;
    bus96.in_vld = (d == 1) && v;
    bus96.flush  = (d == 1) && f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cap_start();
    cap_n[0] = 0; cap_n[1] = 0;
    st_n[0]  = 0; st_n[1]  = 0;
    cap_en   = 1'b1;
  endtask

  function automatic int ones(input int d);
    int c = 0;
    for (int i = 0; i < 1024; i++) if (i < cap_n[d] && cap[d][i]) c++;
    return c;
  endfunction

  initial begin
    rst = 1'b1;
    bus48.in_dat = 1'b0; bus48.in_vld = 1'b0; bus48.flush = 1'b0;
    bus96.in_dat = 1'b0; bus96.in_vld = 1'b0; bus96.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dat48",   bus48.out_dat,   1'b0);
    check("rst_vld48",   bus48.out_vld,   1'b0);
    check("rst_start48", bus48.out_start, 1'b0);
    check("rst_dat96",   bus96.out_dat,   1'b0);
    check("rst_vld96",   bus96.out_vld,   1'b0);
    check("rst_start96", bus96.out_start, 1'b0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // One-hot at received index 1 lands at coded position 16.
    cap_start();
    for (int i = 0; i < 48; i++) drv(0, i == 1, 1'b1, 1'b0);
    idle(52);
    check("oh48_count", cap_n[0], 48);
    check("oh48_starts", st_n[0], 1);
    check("oh48_k16", cap[0][16], 1'b1);
    check("oh48_ones", ones(0), 1);

    // Round trip through a TX interleaver, ten back-to-back symbols.
    for (int k = 0; k < 480; k++) orig[k] = 1'($urandom_range(0, 1));
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < 48; k++)
        tx[s*48 + 3*(k % 16) + k/16] = orig[s*48 + k];
    cap_start();
    for (int i = 0; i < 480; i++) drv(0, tx[i], 1'b1, 1'b0);
    idle(52);
    check("rt_count", cap_n[0], 480);
    check("rt_starts", st_n[0], 10);
    for (int k = 0; k < 480; k++) check($sformatf("rt_bit%0d", k), cap[0][k], orig[k]);

    // Two contiguous symbols must drain without a gap.
    cap_start();
    for (int i = 0; i < 96; i++) drv(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    idle(52);
    check("two_sym_count", cap_n[0], 96);
    check("two_sym_starts", st_n[0], 2);

    // In_Valid toggling 1/0.
    cap_start();
    for (int i = 0; i < 96; i++) drv(0, 1'($urandom_range(0, 1)), (i % 2) == 0, 1'b0);
    idle(52);
    check("toggle_count", cap_n[0], 48);

    // Flush after 20 bits, colliding with a valid bit, then one full symbol.
    cap_start();
    for (int i = 0; i < 20; i++) drv(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    drv(0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 48; i++) drv(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    idle(60);
    check("flush_count", cap_n[0], 48);
    check("flush_starts", st_n[0], 1);

    // 96-bit symbol: received index 7 belongs at coded position 17.
    cap_start();
    for (int i = 0; i < 96; i++) drv(1, i == 7, 1'b1, 1'b0);
    idle(100);
    check("oh96_count", cap_n[1], 96);
    check("oh96_k17", cap[1][17], 1'b1);
    check("oh96_ones", ones(1), 1);
    cap_start();
    for (int i = 0; i < 192; i++) drv(1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    idle(100);
    check("rand96_starts", st_n[1], 2);
    cap_en = 1'b0;

    // Reset in the middle of a drain, then a clean symbol.
    for (int i = 0; i < 48; i++) drv(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    idle(10);
    check("pre_rst_vld", bus48.out_vld, 1'b1);
    rst = 1'b1;
    for (int c = cyc; c < MAXC; c++) begin
      exp_vld[0][c] = 1'b0;
      exp_vld[1][c] = 1'b0;
    end
    #1;
    check("midrst_dat",   bus48.out_dat,   1'b0);
    check("midrst_vld",   bus48.out_vld,   1'b0);
    check("midrst_start", bus48.out_start, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cap_start();
    for (int i = 0; i < 48; i++) drv(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    idle(52);
    check("post_rst_count", cap_n[0], 48);
    check("post_rst_starts", st_n[0], 1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
